mem8x8_arbiter: RTL and testbench

Two-port access controller for the 8x8 memory array. Arbitrates between two requesters with a req/ack handshake, latches the winning request, and sequences one memory access (select, operation, address, write data, read capture) per grant. Sits between the requester logic and the memory's per-row `sel`/`op` inputs; only this block drives the array.

---
 rtl/mem8x8_arbiter.sv | 127 ++++++++++++
 tb/tb_mem8x8_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem8x8_arbiter.sv
// mem8x8_arbiter: two-requester access controller for the 8x8 memory array.
// Arbitrates req/ack requesters, latches the winner and sequences one
// ISSUE/WAIT/DONE memory access per grant.
// Define MEM8X8_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties);
// the default build uses round-robin arbitration.
module mem8x8_arbiter #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic                 clkPE,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [1:0]           wr,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [DW-1:0]        wdata0,
  input  logic [DW-1:0]        wdata1,
  output logic [1:0]           ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [(1<<AW)-1:0]   mem_sel,
  output logic                 mem_op,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int unsigned NR = 1 << AW;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            gnt_q;
  logic            op_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            busy_q;
  logic            win;
  logic            take;

`ifndef MEM8X8_ARB_FIXED_PRIO_EN
  logic            last_q;
`endif

  // Winner selection among currently requesting ports.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
`ifdef MEM8X8_ARB_FIXED_PRIO_EN
      2'b11:   win = 1'b0;
`else
      2'b11:   win = ~last_q;
`endif
      default: win = 1'b0;
    endcase
  end

  assign take = (state_q == StIdle) && (|req);

  // Next-state logic for the access sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clkPE or posedge reset) begin
    if (reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Latch the winning request; these also drive mem_op/mem_wdata between accesses.
  always_ff @(posedge clkPE or posedge reset) begin
    if (reset) begin
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      gnt_q   <= win;
      op_q    <= wr[win];
      addr_q  <= win ? addr1 : addr0;
      wdata_q <= win ? wdata1 : wdata0;
    end
  end

  // Capture array read data at the end of WAIT; writes leave rdata unchanged.
  always_ff @(posedge clkPE or posedge reset) begin
    if (reset)                             rdata_q <= '0;
    else if (state_q == StWait && !op_q)   rdata_q <= mem_rdata;
  end

`ifndef MEM8X8_ARB_FIXED_PRIO_EN
  // Last-served pointer; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clkPE or posedge reset) begin
    if (reset)                  last_q <= 1'b1;
    else if (state_q == StDone) last_q <= gnt_q;
  end
`endif

  // Busy flag registered from the next state so it tracks state exactly.
  always_ff @(posedge clkPE or posedge reset) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= (state_d != StIdle);
  end

  // Array-facing and handshake outputs decoded from the current state.
  always_comb begin
    mem_sel = '0;
    ack     = 2'b00;
    if (state_q == StIssue) mem_sel = {{(NR-1){1'b0}}, 1'b1} << addr_q;
    if (state_q == StDone)  ack = gnt_q ? 2'b10 : 2'b01;
  end

  assign mem_op    = op_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Directed self-checking bench for mem8x8_arbiter with a small array model.
module tb_mem8x8_arbiter;

  logic       clkPE;
  logic       reset;
  logic [1:0] req;
  logic [1:0] wr;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] mem_sel;
  logic       mem_op;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8];
  logic [7:0] exp_rows [8];

  mem8x8_arbiter #(.AW(3), .DW(8)) dut (
    .clkPE     (clkPE),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_sel   (mem_sel),
    .mem_op    (mem_op),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clkPE = 1'b0;
    forever #5 clkPE = ~clkPE;
  end

  // Array model: acts on the selected row mid-cycle, read data registered.
  always @(negedge clkPE) begin
    for (int r = 0; r < 8; r++) begin
      if (mem_sel[r]) begin
        if (mem_op) mem[r] <= mem_wdata;
        else        mem_rdata <= mem[r];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full access starting in IDLE with req already driven.
  task automatic run_access(input string tag, input int g, input logic [7:0] sel,
                            input logic op, input logic chk_rd, input logic [7:0] rd,
                            input logic drop);
    @(posedge clkPE); #1;
    chk({tag, " issue sel"}, 32'(mem_sel), 32'(sel));
    chk({tag, " issue op"}, 32'(mem_op), 32'(op));
    chk({tag, " issue busy"}, 32'(busy), 32'd1);
    chk({tag, " issue ack"}, 32'(ack), 32'd0);
    @(posedge clkPE); #1;
    chk({tag, " wait sel"}, 32'(mem_sel), 32'd0);
    chk({tag, " wait ack"}, 32'(ack), 32'd0);
    @(posedge clkPE); #1;
    chk({tag, " done ack"}, 32'(ack), (g == 1) ? 32'd2 : 32'd1);
    if (chk_rd) chk({tag, " rdata"}, 32'(rdata), 32'(rd));
    if (drop) req = 2'b00;
    @(posedge clkPE); #1;
    chk({tag, " idle ack"}, 32'(ack), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mem[r] = 8'h11 * r[7:0];
    mem_rdata = 8'h00;
    reset = 1'b1;
    req = 2'b00; wr = 2'b00;
    addr0 = 3'd0; addr1 = 3'd0;
    wdata0 = 8'h00; wdata1 = 8'h00;

    // Reset values.
    #12;
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst rdata", 32'(rdata), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst sel", 32'(mem_sel), 32'd0);
    chk("rst op", 32'(mem_op), 32'd0);
    chk("rst wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(posedge clkPE); #1;

    // Requester 0 writes 0xA5 to row 3.
    req = 2'b01; wr = 2'b01; addr0 = 3'd3; wdata0 = 8'hA5;
    run_access("wr0", 0, 8'h08, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("wr0 mem_wdata held", 32'(mem_wdata), 32'hA5);
    chk("wr0 array row3", 32'(mem[3]), 32'hA5);

    // Requester 1 reads row 3 back.
    req = 2'b10; wr = 2'b00; addr1 = 3'd3;
    run_access("rd1", 1, 8'h08, 1'b0, 1'b1, 8'hA5, 1'b1);

    // Address change during ISSUE must not retarget the access.
    req = 2'b01; wr = 2'b00; addr0 = 3'd2;
    @(posedge clkPE); #1;
    addr0 = 3'd5;
    chk("addrchg sel", 32'(mem_sel), 32'h04);
    @(posedge clkPE); #1;
    @(posedge clkPE); #1;
    chk("addrchg ack", 32'(ack), 32'd1);
    chk("addrchg rdata", 32'(rdata), 32'h22);
    req = 2'b00;
    @(posedge clkPE); #1;

    // Back-to-back reads of all rows by requester 1, req held throughout.
    exp_rows[0] = 8'h00; exp_rows[1] = 8'h11; exp_rows[2] = 8'h22; exp_rows[3] = 8'hA5;
    exp_rows[4] = 8'h44; exp_rows[5] = 8'h55; exp_rows[6] = 8'h66; exp_rows[7] = 8'h77;
    req = 2'b10; wr = 2'b00; addr1 = 3'd0;
    for (int r = 0; r < 8; r++) begin
      addr1 = r[2:0];
      run_access($sformatf("b2b%0d", r), 1, 8'h01 << r, 1'b0, 1'b1, exp_rows[r], r == 7);
    end

    // Fresh reset, then simultaneous requests: round-robin order 0,1,0,1.
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clkPE); #1;
    req = 2'b11; wr = 2'b11; addr0 = 3'd1; addr1 = 3'd6; wdata0 = 8'hC3; wdata1 = 8'h3C;
    run_access("tie0", 0, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
    run_access("tie1", 1, 8'h40, 1'b1, 1'b0, 8'h00, 1'b0);
    run_access("tie2", 0, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
    run_access("tie3", 1, 8'h40, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("tie row1", 32'(mem[1]), 32'hC3);
    chk("tie row6", 32'(mem[6]), 32'h3C);

    // Prime rdata with a non-zero value, then abort a read in WAIT.
    req = 2'b01; wr = 2'b00; addr0 = 3'd7;
    run_access("prime", 0, 8'h80, 1'b0, 1'b1, 8'h77, 1'b1);
    req = 2'b01; wr = 2'b00; addr0 = 3'd6;
    @(posedge clkPE); #1;
    @(posedge clkPE); #1;
    reset = 1'b1;
    #1;
    chk("abort ack", 32'(ack), 32'd0);
    chk("abort sel", 32'(mem_sel), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rdata", 32'(rdata), 32'd0);
    req = 2'b00;
    #3;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clkPE); #1;
      chk("post-abort ack", 32'(ack), 32'd0);
      chk("post-abort busy", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
